mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Registered multi-cycle control state machine for the multi-period MIPS core; replaces the purely combinational next-state/enable decode with a clocked controller. Sequences IF/ID/EX/MEM/WB per opcode and adds memory ready handshakes, a parametrised multi-cycle EX stage, and a global stall. It also adds a wait-state timeout into a sticky error state and a retired-instruction counter. Sits between the instruction register/decoder and the PC, regfile, ALU and memory ports.

## Interface
- EX_LAT, 4: cycles spent in EX when `ex_multi`=1; legal range 1..2^CNT_W-1.
- TIMEOUT, 16: maximum consecutive not-ready cycles in IF or MEM; 0 disables the timeout.
- CNT_W, 5: width of the EX and wait counters; must hold max(EX_LAT, TIMEOUT).
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  current IR opcode; `OP_*` codes from defines.v.
- ex_multi  input  1  decoder flag: the current instruction needs EX_LAT EX cycles.
- stall  input  1  global hold.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  IR/PC+4 write strobe.
- regfile_read  output  1  operand latch enable.
- jump_we  output  1  PC jump write.
- branch_we  output  1  PC branch-evaluate write.
- ex_busy  output  1  high while the EX stage is counting.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (SW).
- regfile_write  output  1  regfile write strobe.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- instr_done  output  1  registered one-cycle pulse per retired instruction.
- retired  output  32  retired-instruction count, wraps at 2^32.
- err  output  1  timeout error, sticky.

## Operation
- Outputs are decoded from the registered `state`. Strobes are additionally qualified by ready and `stall`. `stall`=1 forces `ir_we`, `jump_we`, `branch_we` and `regfile_write` to 0.
- Supported opcodes: R_TYPE, ADDI, ORI, LW, SW, BEQ, J.
- Under `stall`=1, state and all counters hold. Requests stay asserted. A ready that coincides with `stall` is ignored and must be re-presented.
- IF: `imem_req`=1.
  - `imem_ready`=1: `ir_we`=1 and next state is ID.
  - Otherwise stay in IF.
- ID: `regfile_read`=1.
  - J: `jump_we`=1, next state IF.
  - Unsupported opcode: `illegal_op`=1, next state IF, not retired.
  - All other supported opcodes: next state EX.
- EX, on entry: the EX counter loads EX_LAT-1 if `ex_multi`=1, else 0.
  - While the counter is nonzero: `ex_busy`=1, the counter decrements, state stays EX.
  - Counter zero: R_TYPE/ADDI/ORI go to WB; LW/SW go to MEM; BEQ sets `branch_we`=1 and goes to IF.
- MEM: `dmem_req`=1; `dmem_we`=1 only for SW.
  - `dmem_ready`=1: LW goes to WB; SW goes to IF.
- WB: `regfile_write`=1 for one cycle, then IF.
- Timeout (TIMEOUT>0): the wait counter increments each non-stalled IF/MEM cycle with ready low. It clears on ready or on any state change. When it reaches TIMEOUT, the next state is ERR.
- ERR: `err`=1; all requests and strobes are 0; the state persists until `rst_n`=0.
- Retirement: every transition into IF from ID (J only), EX, MEM or WB increments `retired` and pulses `instr_done` in the first IF cycle.

## Timing
- `rst_n` low asynchronously sets: state=IF, counters=0, `retired`=0, `err`=0, `instr_done`=0, and forces every output to 0, including `imem_req`.
- First rising edge after reset release: `imem_req`=1. Reset is not counted as a retirement.
- Minimum latencies with zero wait states:
  - J: 2 cycles.
  - BEQ: 3 cycles.
  - R/ADDI/ORI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Multi-cycle EX adds EX_LAT-1 cycles.
- Each wait cycle in IF or MEM adds 1 cycle.
- Strobes are valid for exactly one non-stalled cycle per instruction.
- Reset asserted mid-MEM or mid-EX aborts the instruction immediately; it is not retired.

## Test plan
- Reset, then R_TYPE with `imem_ready`=1 continuously -> `state` goes 0,1,2,4,0. `regfile_write` is high for 1 cycle. `instr_done` pulses in cycle 5. `retired`=1.
- LW with `dmem_ready` low for 3 cycles -> MEM lasts 4 cycles with `dmem_req`=1 and `dmem_we`=0, then WB, then IF. `retired` increments by 1.
- ADDI with `ex_multi`=1, EX_LAT=4 -> EX lasts 4 cycles. `ex_busy` is high for the first 3. WB follows.
- J -> IF,ID,IF with a 1-cycle `jump_we`. BEQ -> IF,ID,EX,IF with `branch_we` in EX. Opcode 6'h3F -> `illegal_op` pulse, IF next, `retired` unchanged.
- SW with `dmem_ready`=0 and TIMEOUT=16 -> `state`=7 after 16 MEM cycles. `err`=1 and outputs stay 0 until `rst_n`=0, which returns `state`=0 asynchronously.
- `stall`=1 for 2 cycles in IF with `imem_ready`=1 -> no `ir_we` and `state` holds at 0. After `stall` drops: `ir_we` pulses once and state moves to ID.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- registered multi-cycle controller for the multi-period MIPS core.
//
// Sequences IF/ID/EX/MEM/WB per opcode with instruction/data memory ready
// handshakes, a multi-cycle EX stage, a global stall, a wait-state timeout
// into a sticky error state and a retired-instruction counter.
//
// Ports:
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   opcode[5:0]       current IR opcode
//   ex_multi          current instruction needs EX_LAT EX cycles
//   stall             global hold (state and counters freeze, strobes drop)
//   imem_ready        instruction memory data valid
//   dmem_ready        data memory access complete
//   state[2:0]        IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7
//   imem_req, ir_we, regfile_read, jump_we, branch_we, ex_busy,
//   dmem_req, dmem_we, regfile_write, illegal_op   datapath controls
//   instr_done        one-cycle pulse in the first IF cycle after retirement
//   retired[31:0]     retired-instruction count (wraps)
//   err               sticky wait-state timeout error
module mc_control_fsm #(
    parameter int EX_LAT  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        ex_multi,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic [2:0]  state,
    output logic        imem_req,
    output logic        ir_we,
    output logic        regfile_read,
    output logic        jump_we,
    output logic        branch_we,
    output logic        ex_busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        regfile_write,
    output logic        illegal_op,
    output logic        instr_done,
    output logic [31:0] retired,
    output logic        err
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_ERR = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] EX_LOAD     = CNT_W'(EX_LAT - 1);
    localparam logic [CNT_W:0]   TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT);
    localparam logic             TIMEOUT_EN  = (TIMEOUT > 0);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CNT_W-1:0] ex_cnt_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W:0]   wait_inc_s;
    logic             run_r;
    logic             err_r;
    logic             instr_done_r;
    logic [31:0]      retired_r;
    logic             active_s;
    logic             waiting_s;
    logic             timeout_hit_s;
    logic             ex_load_s;
    logic             retire_s;
    logic             is_alu_s;
    logic             is_mem_s;
    logic             is_supported_s;
    logic             imem_req_s;
    logic             ir_we_s;
    logic             regfile_read_s;
    logic             jump_we_s;
    logic             branch_we_s;
    logic             ex_busy_s;
    logic             dmem_req_s;
    logic             dmem_we_s;
    logic             regfile_write_s;
    logic             illegal_op_s;

    // Opcode classification and wait-state timeout detection.
    always_comb begin
        is_alu_s       = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_ORI);
        is_mem_s       = (opcode == OP_LW) || (opcode == OP_SW);
        is_supported_s = is_alu_s || is_mem_s || (opcode == OP_BEQ) || (opcode == OP_J);
        // run_r is low only until the first edge after reset, so nothing
        // advances or strobes while the controller is still coming out of reset.
        active_s       = run_r & ~stall;
        waiting_s      = ((state_r == S_IF) & ~imem_ready) | ((state_r == S_MEM) & ~dmem_ready);
        wait_inc_s     = {1'b0, wait_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        timeout_hit_s  = TIMEOUT_EN & active_s & waiting_s & (wait_inc_s == TIMEOUT_LIM);
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        next_state_s    = state_r;
        ex_load_s       = 1'b0;
        retire_s        = 1'b0;
        imem_req_s      = 1'b0;
        ir_we_s         = 1'b0;
        regfile_read_s  = 1'b0;
        jump_we_s       = 1'b0;
        branch_we_s     = 1'b0;
        ex_busy_s       = 1'b0;
        dmem_req_s      = 1'b0;
        dmem_we_s       = 1'b0;
        regfile_write_s = 1'b0;
        illegal_op_s    = 1'b0;
        case (state_r)
            S_IF: begin
                imem_req_s = run_r;
                if (timeout_hit_s) begin
                    next_state_s = S_ERR;
                end else if (active_s && imem_ready) begin
                    ir_we_s      = 1'b1;
                    next_state_s = S_ID;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_ID: begin
                regfile_read_s = 1'b1;
                if (!active_s) begin
                    next_state_s = S_ID;
                end else if (opcode == OP_J) begin
                    jump_we_s    = 1'b1;
                    retire_s     = 1'b1;
                    next_state_s = S_IF;
                end else if (!is_supported_s) begin
                    illegal_op_s = 1'b1;
                    next_state_s = S_IF;
                end else begin
                    ex_load_s    = 1'b1;
                    next_state_s = S_EX;
                end
            end
            S_EX: begin
                ex_busy_s = (ex_cnt_r != CNT_ZERO);
                if (!active_s || (ex_cnt_r != CNT_ZERO)) begin
                    next_state_s = S_EX;
                end else if (is_alu_s) begin
                    next_state_s = S_WB;
                end else if (is_mem_s) begin
                    next_state_s = S_MEM;
                end else if (opcode == OP_BEQ) begin
                    branch_we_s  = 1'b1;
                    retire_s     = 1'b1;
                    next_state_s = S_IF;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (opcode == OP_SW);
                if (timeout_hit_s) begin
                    next_state_s = S_ERR;
                end else if (active_s && dmem_ready) begin
                    if (opcode == OP_LW) begin
                        next_state_s = S_WB;
                    end else begin
                        retire_s     = 1'b1;
                        next_state_s = S_IF;
                    end
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                if (active_s) begin
                    regfile_write_s = 1'b1;
                    retire_s        = 1'b1;
                    next_state_s    = S_IF;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_ERR: begin
                next_state_s = S_ERR;
            end
            default: begin
                // Unreachable encodings are treated as a fault.
                next_state_s = S_ERR;
            end
        endcase
    end

    // State register and the post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
            run_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            run_r   <= 1'b1;
        end
    end

    // EX latency counter: loaded on ID->EX, counts down while in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_r <= CNT_ZERO;
        end else if (active_s && ex_load_s) begin
            ex_cnt_r <= ex_multi ? EX_LOAD : CNT_ZERO;
        end else if (active_s && (state_r == S_EX) && (ex_cnt_r != CNT_ZERO)) begin
            ex_cnt_r <= ex_cnt_r - CNT_W'(1);
        end else begin
            ex_cnt_r <= ex_cnt_r;
        end
    end

    // Consecutive not-ready counter for IF/MEM; cleared on ready or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (!active_s) begin
            wait_cnt_r <= wait_cnt_r;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (waiting_s) begin
            wait_cnt_r <= wait_inc_s[CNT_W-1:0];
        end else begin
            wait_cnt_r <= CNT_ZERO;
        end
    end

    // Retirement pulse and counter; sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_done_r <= 1'b0;
            retired_r    <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            instr_done_r <= retire_s;
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
            if (next_state_s == S_ERR) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign state         = state_r;
    assign imem_req      = imem_req_s;
    assign ir_we         = ir_we_s;
    assign regfile_read  = regfile_read_s;
    assign jump_we       = jump_we_s;
    assign branch_we     = branch_we_s;
    assign ex_busy       = ex_busy_s;
    assign dmem_req      = dmem_req_s;
    assign dmem_we       = dmem_we_s;
    assign regfile_write = regfile_write_s;
    assign illegal_op    = illegal_op_s;
    assign instr_done    = instr_done_r;
    assign retired       = retired_r;
    assign err           = err_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm. Each instruction pushes a hand-written
// expected record (state trace, per-output strobe counts, instr_done,
// retired, err); the monitor closes a record each time the DUT enters IF from
// another state or enters ERR, and compares what it observed.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        ex_multi;
    logic        stall;
    logic        imem_ready;
    logic        dmem_ready;
    logic [2:0]  state;
    logic        imem_req, ir_we, regfile_read, jump_we, branch_we, ex_busy;
    logic        dmem_req, dmem_we, regfile_write, illegal_op, instr_done, err;
    logic [31:0] retired;

    mc_control_fsm #(.EX_LAT(4), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .ex_multi(ex_multi),
        .stall(stall), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .imem_req(imem_req), .ir_we(ir_we),
        .regfile_read(regfile_read), .jump_we(jump_we), .branch_we(branch_we),
        .ex_busy(ex_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .regfile_write(regfile_write), .illegal_op(illegal_op),
        .instr_done(instr_done), .retired(retired), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe count slots: [9] imem_req [8] ir_we [7] regfile_read [6] jump_we
    // [5] branch_we [4] ex_busy [3] dmem_req [2] dmem_we [1] regfile_write [0] illegal_op
    typedef struct {
        int              id;
        logic [95:0]     trace;
        int              len;
        logic [9:0][4:0] cnt;
        logic            done;
        logic [31:0]     ret;
        logic            err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_retired = 32'd0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drive one instruction cycle by cycle. tr is the expected state per cycle
    // ("0"=IF ... "4"=WB); readies are presented on the last IF / last MEM cycle.
    task automatic run_instr(input int id, input string tr, input logic [5:0] op,
                             input logic multi, input int stall_n, input logic hang,
                             input logic [9:0][4:0] cnt, input logic retire_k,
                             input logic err_k);
        exp_t e;
        int   lz;
        int   l3;
        byte  c;
        e.trace = '0;
        e.len   = tr.len();
        lz = 0;
        l3 = -1;
        for (int i = 0; i < tr.len(); i++) begin
            c = tr[i];
            e.trace[3*i +: 3] = 3'(c - 8'h30);
            if (c == 8'h30 && lz == i) lz = i + 1;
            if (c == 8'h33) l3 = i;
        end
        if (retire_k) exp_retired = exp_retired + 32'd1;
        e.id = id; e.cnt = cnt; e.done = retire_k; e.ret = exp_retired; e.err = err_k;
        exp_q.push_back(e);
        for (int i = 0; i < tr.len(); i++) begin
            c          = tr[i];
            opcode     = op;
            ex_multi   = multi;
            stall      = (i < stall_n);
            imem_ready = (c == 8'h30) && ((i < stall_n) || (i == lz - 1));
            dmem_ready = (c == 8'h33) && !hang && (i == l3);
            @(posedge clk); #1;
        end
        stall      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // Monitor: accumulate per-cycle observations and score at each boundary.
    initial begin
        logic [95:0]     acc_trace;
        int              acc_len;
        logic [9:0][4:0] acc_cnt;
        logic [2:0]      prev_state;
        logic            prev_valid;
        logic            boundary;
        exp_t            e;
        acc_trace = '0; acc_len = 0; acc_cnt = '0; prev_state = 3'd0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_trace = '0; acc_len = 0; acc_cnt = '0; prev_valid = 1'b0;
            end else begin
                boundary = prev_valid && (((state == 3'd0) && (prev_state != 3'd0)) ||
                                          ((state == 3'd7) && (prev_state != 3'd7)));
                if (boundary) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 96'(state), 96'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("i%0d_trace", e.id), acc_trace, e.trace);
                        check($sformatf("i%0d_len", e.id), 96'(acc_len), 96'(e.len));
                        check($sformatf("i%0d_strobe_counts", e.id), 96'(acc_cnt), 96'(e.cnt));
                        check($sformatf("i%0d_instr_done", e.id), 96'(instr_done), 96'(e.done));
                        check($sformatf("i%0d_retired", e.id), 96'(retired), 96'(e.ret));
                        check($sformatf("i%0d_err", e.id), 96'(err), 96'(e.err));
                    end
                    acc_trace = '0; acc_len = 0; acc_cnt = '0;
                end
                if (state == 3'd7) begin
                    check("err_outputs_quiet",
                          96'({imem_req, ir_we, regfile_read, jump_we, branch_we, ex_busy,
                               dmem_req, dmem_we, regfile_write, illegal_op, err}),
                          96'h001);
                end
                if (acc_len < 32) begin
                    acc_trace[3*acc_len +: 3] = state;
                    acc_len++;
                end
                acc_cnt[9] = acc_cnt[9] + 5'(imem_req);
                acc_cnt[8] = acc_cnt[8] + 5'(ir_we);
                acc_cnt[7] = acc_cnt[7] + 5'(regfile_read);
                acc_cnt[6] = acc_cnt[6] + 5'(jump_we);
                acc_cnt[5] = acc_cnt[5] + 5'(branch_we);
                acc_cnt[4] = acc_cnt[4] + 5'(ex_busy);
                acc_cnt[3] = acc_cnt[3] + 5'(dmem_req);
                acc_cnt[2] = acc_cnt[2] + 5'(dmem_we);
                acc_cnt[1] = acc_cnt[1] + 5'(regfile_write);
                acc_cnt[0] = acc_cnt[0] + 5'(illegal_op);
                prev_state = state;
                prev_valid = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end within 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; opcode = 6'h00; ex_multi = 1'b0; stall = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #12;
        check("rst_state", 96'(state), 96'd0);
        check("rst_outputs_zero",
              96'({imem_req, ir_we, regfile_read, jump_we, branch_we, ex_busy, dmem_req,
                   dmem_we, regfile_write, illegal_op, instr_done, err}), 96'd0);
        check("rst_retired", 96'(retired), 96'd0);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(1,  "0124",     6'h00, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd1,5'd0}, 1'b1, 1'b0);
        run_instr(2,  "01233334", 6'h23, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd4,5'd0,5'd1,5'd0}, 1'b1, 1'b0);
        run_instr(3,  "0122224",  6'h08, 1'b1, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd3,5'd0,5'd0,5'd1,5'd0}, 1'b1, 1'b0);
        run_instr(4,  "01",       6'h02, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 1'b1, 1'b0);
        run_instr(5,  "012",      6'h04, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0}, 1'b1, 1'b0);
        run_instr(6,  "01",       6'h3F, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd1}, 1'b0, 1'b0);
        run_instr(7,  "000124",   6'h0D, 1'b0, 2, 1'b0,
                  {5'd3,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd1,5'd0}, 1'b1, 1'b0);
        run_instr(8,  "0123",     6'h2B, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd1,5'd1,5'd0,5'd0}, 1'b1, 1'b0);
        run_instr(9,  "000124",   6'h00, 1'b0, 0, 1'b0,
                  {5'd3,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd1,5'd0}, 1'b1, 1'b0);
        run_instr(10, "0123333333333333333", 6'h2B, 1'b0, 0, 1'b1,
                  {5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd16,5'd16,5'd0,5'd0}, 1'b0, 1'b1);

        // ERR must ignore later readies and persist until reset.
        imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("err_async_reset_state", 96'(state), 96'd0);
        check("err_async_reset_err", 96'(err), 96'd0);
        check("err_async_reset_imem_req", 96'(imem_req), 96'd0);
        check("err_async_reset_retired", 96'(retired), 96'd0);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_retired = 32'd0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(11, "01", 6'h02, 1'b0, 0, 1'b0,
                  {5'd1,5'd1,5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 1'b1, 1'b0);

        // Multi-cycle ADDI aborted by reset while EX is still counting.
        opcode = 6'h08; ex_multi = 1'b1; imem_ready = 1'b1;
        @(posedge clk); #1 imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_ex_busy", 96'({state, ex_busy}), 96'({3'd2, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", 96'(state), 96'd0);
        check("abort_outputs_zero",
              96'({imem_req, ex_busy, regfile_write, instr_done, err}), 96'd0);
        check("scoreboard_drained", 96'(exp_q.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
